// File: rtl/minor_pkg.sv
// Shared types for the serial row loader: word width, loader state encoding, lane slicing.
package minor_pkg;

    localparam int unsigned WORD_W = 16;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StShift = 3'd1,
        StWrite = 3'd2,
        StCheck = 3'd3,
        StDone  = 3'd4
    } loader_state_e;

    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/serial_word_shift.sv
// 16-bit LSB-first deserializer; word/word_vld present the completed word during its last bit.
module serial_word_shift (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s,
    input  logic        s_vld,
    input  logic        en,
    output logic [15:0] word,
    output logic        word_vld
);

    logic [15:0] shreg_q;
    logic [3:0]  cnt_q;

    // Combinational view lets the caller act on the word at the edge that samples its last bit.
    assign word     = {s, shreg_q[15:1]};
    assign word_vld = en & s_vld & (cnt_q == 4'd15);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (en && s_vld) begin
            shreg_q <= word;
            cnt_q   <= cnt_q + 4'd1;
        end
    end

endmodule

// File: rtl/serial_row_loader.sv
// Assembles serial LSB-first words into memory rows; optional trailing checksum
// check when LOADER_CHECKSUM_EN is defined.
module serial_row_loader
    import minor_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned MAX_FEATURES = 15,
    parameter int unsigned WORD_W       = minor_pkg::WORD_W,
    parameter int unsigned DATA_WIDTH   = WORD_W * (MAX_FEATURES + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  S,
    input  logic                  S_VLD,
    input  logic [3:0]            feat,
    input  logic [ADDR_WIDTH-1:0] data_points,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  load_done,
    output logic                  load_err
);

    loader_state_e         state_q, state_d;
    logic [3:0]            feat_q, feat_d;
    logic [3:0]            word_idx_q, word_idx_d;
    logic [ADDR_WIDTH-1:0] dp_q, dp_d;
    logic [ADDR_WIDTH-1:0] row_idx_q, row_idx_d;
    logic [DATA_WIDTH-1:0] row_q, row_d;
    logic                  shift_en;
    logic                  word_vld;
    logic [15:0]           word;

    assign shift_en = (state_q != StDone);

    serial_word_shift u_shift (
        .clk      (CLK),
        .rst_n    (RST),
        .s        (S),
        .s_vld    (S_VLD),
        .en       (shift_en),
        .word     (word),
        .word_vld (word_vld)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] xor_q, xor_d;
    logic        err_q, err_d;
    localparam loader_state_e LastState = StCheck;
`else
    localparam loader_state_e LastState = StDone;
`endif

    always_comb begin
        state_d    = state_q;
        feat_d     = feat_q;
        dp_d       = dp_q;
        word_idx_d = word_idx_q;
        row_idx_d  = row_idx_q;
        row_d      = row_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d      = xor_q;
        err_d      = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (S_VLD) begin
                    state_d    = StShift;
                    feat_d     = feat;
                    dp_d       = data_points;
                    word_idx_d = feat;
                end
            end
            StShift: begin
                if (word_vld) begin
                    row_d[lane_lsb(32'(word_idx_q), WORD_W) +: WORD_W] = word;
`ifdef LOADER_CHECKSUM_EN
                    xor_d = xor_q ^ word;
`endif
                    if (word_idx_q == 4'd0) begin
                        state_d    = StWrite;
                        word_idx_d = feat_q;
                    end else begin
                        word_idx_d = word_idx_q - 4'd1;
                    end
                end
            end
            StWrite: begin
                row_d = '0;
                // Last row holds row_idx so a full address range never wraps.
                if (row_idx_q == dp_q) begin
                    state_d = LastState;
                end else begin
                    row_idx_d = row_idx_q + 1'b1;
                    state_d   = StShift;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                if (word_vld) begin
                    err_d   = (word != xor_q);
                    state_d = StDone;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= StIdle;
            feat_q     <= '0;
            dp_q       <= '0;
            word_idx_q <= '0;
            row_idx_q  <= '0;
            row_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            feat_q     <= feat_d;
            dp_q       <= dp_d;
            word_idx_q <= word_idx_d;
            row_idx_q  <= row_idx_d;
            row_q      <= row_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
            err_q      <= err_d;
`endif
        end
    end

    always_comb begin
        wr_data = row_q;
        for (int unsigned j = 0; j <= MAX_FEATURES; j++) begin
            if (j > 32'(feat_q)) wr_data[lane_lsb(j, WORD_W) +: WORD_W] = '0;
        end
    end

    assign wr_en     = (state_q == StWrite);
    assign wr_addr   = row_idx_q;
    assign load_done = (state_q == StDone);
`ifdef LOADER_CHECKSUM_EN
    assign load_err  = err_q;
`else
    assign load_err  = 1'b0;
`endif

endmodule

// File: doc/serial_row_loader.md
# serial_row_loader

Receives the training set as a serial bitstream and assembles it into full-width rows for the gradient-descent trainer's data memory. Each row is `feat+1` 16-bit words, each sent LSB first, and the block writes one `DATA_WIDTH` word per row. It sits directly upstream of the trainer core. The core waits for `load_done` before it starts its epochs.

## Interface
- `ADDR_WIDTH`, default 12: width of the row address and the `data_points` field.
- `MAX_FEATURES`, default 15: highest feature index; a row has up to `MAX_FEATURES+1` lanes.
- `WORD_W`, default 16: bits per feature word (Q-format fixed point, opaque to this block).
- `DATA_WIDTH`, default `WORD_W*(MAX_FEATURES+1)`: width of a memory row.
- `CLK`, in, 1: clock; all logic is on the rising edge.
- `RST`, in, 1: synchronous, active-low reset.
- `S`, in, 1: serial data bit.
- `S_VLD`, in, 1: `S` is valid this cycle.
- `feat`, in, 4: highest feature index in use; a row carries `feat+1` words.
- `data_points`, in, `ADDR_WIDTH`: highest row index; `data_points+1` rows are loaded.
- `wr_en`, out, 1: one-cycle memory write strobe.
- `wr_addr`, out, `ADDR_WIDTH`: row index being written.
- `wr_data`, out, `DATA_WIDTH`: row; lane j is `[WORD_W*j +: WORD_W]`.
- `load_done`, out, 1: all rows written; held high until reset.
- `load_err`, out, 1: checksum mismatch; present only with `LOADER_CHECKSUM_EN`, otherwise tied to 0.

## Operation
- States:
  - IDLE: waiting for the first valid bit.
  - SHIFT: receiving bits.
  - WRITE: one cycle, issues the row write.
  - CHECK: checksum build only.
  - DONE: load complete.
- IDLE → SHIFT on the first cycle with `S_VLD=1`. That bit is consumed, and `feat` and `data_points` are latched in the same cycle. Later changes to either input are ignored until reset.
- SHIFT:
  - Each `S_VLD=1` cycle shifts `S` into the word register from the MSB side, so the first bit ends up in bit 0.
  - `S_VLD=0` cycles stall: the bit counter and all state hold.
- On the 16th bit, the word is placed in lane `word_idx`. Words arrive in the order lane `feat` first, down to lane 0.
- When the lane-0 word completes, go to WRITE.
- WRITE:
  - `wr_en=1`, `wr_addr=row_idx`, `wr_data` = the row buffer, with lanes above `feat` forced to 0.
  - Then `row_idx` increments and the row buffer clears.
  - The next state is SHIFT, or DONE when `row_idx==data_points` (CHECK in the checksum build).
- A bit presented with `S_VLD=1` during WRITE is accepted as the first bit of the next word. No bit is dropped.
- DONE: `load_done=1`, and `S`/`S_VLD` are ignored.
- Boundary cases:
  - `feat=0`: one word per row.
  - `data_points=0`: exactly one row.
  - `data_points=2^ADDR_WIDTH-1`: `row_idx` must not wrap before DONE.
- Reset mid-row discards the partial word and row. No write is issued.

## Timing
- Reset values: `wr_en=0`, `wr_addr=0`, `wr_data=0`, `load_done=0`, `load_err=0`. All counters are 0 and the state is IDLE.
- If the last bit of a row is sampled at edge k, `wr_en` is high in the cycle after edge k and low after edge k+1.
- Without the checksum, `load_done` rises one cycle after the final `wr_en` pulse.
- Back-to-back rows: the minimum spacing between `wr_en` pulses is `16*(feat+1)` cycles.
- `wr_addr` and `wr_data` are meaningful only while `wr_en=1`.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - After the final row, one extra 16-bit word (LSB first) is received in CHECK.
  - It is compared to the XOR of every data word received.
  - `load_done` rises one cycle after the checksum's last bit.
  - `load_err=1` on mismatch, held with `load_done`.
- `LOADER_CHECKSUM_EN` undefined: no CHECK state, no XOR register, `load_err` tied to 0.

## Structure
- Package `minor_pkg`: `WORD_W`, the loader state enum, and a lane-slice function.
- Sub-module `serial_word_shift`: a 16-bit shift register with a 4-bit bit counter, `S_VLD` stall, and a one-cycle `word_vld` pulse. The FSM, row buffer, and row/word counters live in `serial_row_loader`.

## Test plan
- `feat=1`, `data_points=0`, words sent 0x1234 then 0xABCD, continuous `S_VLD` → one write: `wr_addr=0`, lane1=0x1234, lane0=0xABCD, lanes 2..15 = 0. `load_done` rises one cycle after `wr_en`.
- `feat=11`, `data_points=4`, 60 random words → exactly 5 `wr_en` pulses at addresses 0..4, contents match the model, spacing is 192 cycles.
- Same stream with `S_VLD` low on every third cycle → identical writes, only later. No bit lost or duplicated.
- `RST` low for one cycle after 40 bits of row 2, then a full restream with `feat=3` → no write from the aborted stream, rows restart at address 0.
- Extra bits after `load_done` with `feat`/`data_points` changed → no further `wr_en`, outputs unchanged.
- Checksum build, `feat=0`, `data_points=1`, words 0x00FF and 0x0F0F:
  - checksum 0x0FF0 → `load_done=1`, `load_err=0`.
  - checksum 0x0000 → `load_err=1`.
